// File: rtl/text_console_writer_if.sv
// Byte stream, frame buffer strobes and cursor/status of the text console writer.
// Latency: none, wires only.
// Backpressure: the host holds in_vld-style in_valid until the writer raises in_ready.
interface text_console_writer_if #(
    parameter int ADDR_W = 11,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5
) ();
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] address;
    logic              cs_n;
    logic              oe_n;
    logic              we_n;
    logic [COL_W-1:0]  cursor_col;
    logic [ROW_W-1:0]  cursor_row;
    logic              busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, address, cs_n, oe_n, we_n, cursor_col, cursor_row, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, address, cs_n, oe_n, we_n, cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/text_console_writer.sv
// Cursor-tracking ASCII writer for an 80x25 frame buffer, with wrap, scroll and clear.
// Latency: printable byte written the cycle after accept; in_ready returns 2 edges after accept.
// Backpressure: in_ready is low for the whole of any clear, write, newline or scroll sequence.
module text_console_writer #(
    parameter int         COLS   = 80,
    parameter int         ROWS   = 25,
    parameter int         ADDR_W = 11,
    parameter logic [7:0] BLANK  = 8'h20
) (
    input  logic                    clock,
    input  logic                    reset_n,
    text_console_writer_if.slave    bus,
    inout  wire  [7:0]              data
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_SRC  = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] BOT_ROW   = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WRITE,
        S_NEWLINE,
        S_SCROLL_RD,
        S_SCROLL_WR,
        S_BLANK_ROW
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              ph_q, ph_d;
    logic [7:0]        byte_q, byte_d;
    logic              adv_q, adv_d;
    logic [7:0]        rdat_q, rdat_d;
    logic              in_ready_q, in_ready_d;

    logic              accept;
    logic [ADDR_W-1:0] cell_addr;
    logic [ADDR_W-1:0] addr_c;
    logic [7:0]        wdat_c;
    logic              cs_c, oe_c, we_c;

    assign accept    = bus.in_valid & in_ready_q;
    assign cell_addr = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        idx_d   = idx_q;
        ph_d    = ph_q;
        byte_d  = byte_q;
        adv_d   = adv_q;
        rdat_d  = rdat_q;
        addr_c  = '0;
        wdat_c  = BLANK;
        cs_c    = 1'b0;
        oe_c    = 1'b0;
        we_c    = 1'b0;

        unique case (state_q)
            S_CLEAR: begin
                cs_c   = 1'b1;
                we_c   = 1'b1;
                addr_c = idx_q;
                if (idx_q == LAST_CELL) begin
                    idx_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
                        byte_d  = bus.in_data;
                        adv_d   = 1'b1;
                        state_d = S_WRITE;
                    end else if (bus.in_data == 8'h0D) begin
                        col_d = '0;
                    end else if (bus.in_data == 8'h0A) begin
                        state_d = S_NEWLINE;
                    end else if (bus.in_data == 8'h08) begin
                        // Backspace blanks the cell it steps back onto, without advancing.
                        if (col_q != '0) begin
                            col_d   = col_q - 1'b1;
                            byte_d  = BLANK;
                            adv_d   = 1'b0;
                            state_d = S_WRITE;
                        end
                    end else if (bus.in_data == 8'h0C) begin
                        idx_d   = '0;
                        state_d = S_CLEAR;
                    end
                end
            end
            S_WRITE: begin
                cs_c    = 1'b1;
                we_c    = 1'b1;
                addr_c  = cell_addr;
                wdat_c  = byte_q;
                state_d = S_IDLE;
                if (adv_q) begin
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = S_NEWLINE;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_NEWLINE: begin
                if (row_q != LAST_ROW) begin
                    row_d   = row_q + 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = '0;
                    ph_d    = 1'b0;
                    state_d = S_SCROLL_RD;
                end
            end
            S_SCROLL_RD: begin
                // Address held for two cycles; RAM data is valid by the second edge.
                cs_c   = 1'b1;
                oe_c   = 1'b1;
                addr_c = idx_q + COLS_A;
                if (ph_q) begin
                    rdat_d  = data;
                    ph_d    = 1'b0;
                    state_d = S_SCROLL_WR;
                end else begin
                    ph_d = 1'b1;
                end
            end
            S_SCROLL_WR: begin
                cs_c   = 1'b1;
                we_c   = 1'b1;
                addr_c = idx_q;
                wdat_c = rdat_q;
                if (idx_q == LAST_SRC) begin
                    idx_d   = BOT_ROW;
                    state_d = S_BLANK_ROW;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SCROLL_RD;
                end
            end
            S_BLANK_ROW: begin
                cs_c   = 1'b1;
                we_c   = 1'b1;
                addr_c = idx_q;
                if (idx_q == LAST_CELL) begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = S_CLEAR;
            end
        endcase

        // Ready reopens only after a full cycle back in IDLE, so every printable byte
        // sees the bus go quiet before the next one is taken.
        in_ready_d = (state_d == S_IDLE) && (state_q == S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_CLEAR;
            col_q      <= '0;
            row_q      <= '0;
            idx_q      <= '0;
            ph_q       <= 1'b0;
            byte_q     <= BLANK;
            adv_q      <= 1'b0;
            rdat_q     <= BLANK;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            idx_q      <= idx_d;
            ph_q       <= ph_d;
            byte_q     <= byte_d;
            adv_q      <= adv_d;
            rdat_q     <= rdat_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Strobes are gated by reset so an aborted sequence releases the bus at once.
    assign bus.cs_n       = ~(cs_c & reset_n);
    assign bus.oe_n       = ~(oe_c & reset_n);
    assign bus.we_n       = ~(we_c & reset_n);
    assign bus.address    = addr_c;
    assign data           = bus.we_n ? 8'hzz : wdat_c;
    assign bus.in_ready   = in_ready_q;
    assign bus.cursor_col = col_q;
    assign bus.cursor_row = row_q;
    assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer with a 1-cycle-latency frame buffer RAM model.
module tb_text_console_writer;
    logic clock = 1'b0;
    logic reset_n;
    wire  [7:0] data;

    text_console_writer_if tif ();

    text_console_writer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (tif.slave),
        .data    (data)
    );

    always #10 clock = ~clock;

    logic [7:0]  mem [0:2047] = '{default: 8'hAA};
    logic [7:0]  exp_mem [0:1999];
    logic [7:0]  rd_q = 8'h00;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          bus_cnt = 0;
    int          oob_cnt = 0;
    logic [10:0] last_addr = '0;
    logic [7:0]  last_dat = '0;

    assign data = (!tif.cs_n && !tif.oe_n) ? rd_q : 8'hzz;

    always @(posedge clock) begin
        rd_q <= mem[tif.address];
        if (!tif.cs_n) bus_cnt <= bus_cnt + 1;
        if (!tif.cs_n && !tif.oe_n) rd_cnt <= rd_cnt + 1;
        if (!tif.cs_n && !tif.we_n) begin
            mem[tif.address] <= data;
            wr_cnt    <= wr_cnt + 1;
            last_addr <= tif.address;
            last_dat  <= data;
            if (tif.address >= 11'd2000) oob_cnt <= oob_cnt + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int count_val(input int lo, input int hi, input logic [7:0] v);
        int n = 0;
        for (int a = lo; a <= hi; a++) if (mem[a] == v) n++;
        return n;
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (tif.in_ready !== 1'b1 && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk(tag, 32'(tif.in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clock);
        tif.in_data  = b;
        tif.in_valid = 1'b1;
        while (tif.in_ready !== 1'b1 && n < 8000) begin
            @(negedge clock);
            n++;
        end
        chk("send_ready", 32'(tif.in_ready), 32'd1);
        @(posedge clock);
        #1 tif.in_valid = 1'b0;
    endtask

    task automatic chk_cursor(input string tag, input int row, input int col);
        chk({tag, "_row"}, 32'(tif.cursor_row), 32'(row));
        chk({tag, "_col"}, 32'(tif.cursor_col), 32'(col));
    endtask

    initial begin
        int w0, b0, r0, bad;
        reset_n      = 1'b0;
        tif.in_valid = 1'b0;
        tif.in_data  = 8'h00;

        // T1: reset values, then the power-on clear
        repeat (3) @(negedge clock);
        chk("rst_cs_n", 32'(tif.cs_n), 32'd1);
        chk("rst_oe_n", 32'(tif.oe_n), 32'd1);
        chk("rst_we_n", 32'(tif.we_n), 32'd1);
        chk("rst_addr", 32'(tif.address), 32'd0);
        chk("rst_ready", 32'(tif.in_ready), 32'd0);
        chk("rst_busy", 32'(tif.busy), 32'd1);
        chk_cursor("rst", 0, 0);
        w0 = wr_cnt;
        reset_n = 1'b1;
        wait_idle(2100, "clear_timeout");
        chk("clear_writes", 32'(wr_cnt - w0), 32'd2000);
        chk("clear_blanks", 32'(count_val(0, 1999, 8'h20)), 32'd2000);
        chk("clear_no_oob", 32'(mem[2000]), 32'hAA);
        chk("clear_oob_cnt", 32'(oob_cnt), 32'd0);
        chk("clear_busy", 32'(tif.busy), 32'd0);
        chk_cursor("clear", 0, 0);

        // T2: single printable byte and ready timing
        w0 = wr_cnt;
        send(8'h41);
        @(negedge clock);
        chk("A_ready_drop", 32'(tif.in_ready), 32'd0);
        @(negedge clock);
        chk("A_ready_c2", 32'(tif.in_ready), 32'd0);
        @(negedge clock);
        chk("A_ready_back", 32'(tif.in_ready), 32'd1);
        chk("A_writes", 32'(wr_cnt - w0), 32'd1);
        chk("A_addr", 32'(last_addr), 32'd0);
        chk("A_data", 32'(last_dat), 32'h41);
        chk_cursor("A", 0, 1);

        // T3: full row from (3,0) wraps to (4,0); BS at col 0 is a no-op
        repeat (3) send(8'h0A);
        send(8'h0D);
        wait_idle(20, "lf_timeout");
        chk_cursor("pos3", 3, 0);
        for (int i = 0; i < 80; i++) send(8'h78);
        wait_idle(20, "row_timeout");
        chk("row_last_addr", 32'(last_addr), 32'd319);
        chk("row_x_count", 32'(count_val(240, 319, 8'h78)), 32'd80);
        chk_cursor("wrap", 4, 0);
        send(8'h0D);
        b0 = bus_cnt;
        send(8'h08);
        repeat (4) @(negedge clock);
        chk("bs0_no_bus", 32'(bus_cnt - b0), 32'd0);
        chk_cursor("bs0", 4, 0);
        send(8'h51);
        wait_idle(20, "q_timeout");
        chk("q_mem", 32'(mem[320]), 32'h51);
        send(8'h08);
        wait_idle(20, "bs_timeout");
        chk("bs_mem", 32'(mem[320]), 32'h20);
        chk("bs_addr", 32'(last_addr), 32'd320);
        chk_cursor("bs", 4, 0);

        // T4: scroll from (24,5)
        repeat (20) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        wait_idle(20, "abc_timeout");
        chk_cursor("pre_scroll", 24, 5);
        for (int a = 0; a < 2000; a++) exp_mem[a] = (a < 1920) ? mem[a + 80] : 8'h20;
        b0 = bus_cnt;
        r0 = rd_cnt;
        send(8'h0A);
        wait_idle(7000, "scroll_timeout");
        chk("scroll_bus", 32'(bus_cnt - b0), 32'd5840);
        chk("scroll_reads", 32'(rd_cnt - r0), 32'd3840);
        bad = 0;
        for (int a = 0; a < 2000; a++) if (mem[a] != exp_mem[a]) bad++;
        chk("scroll_content", 32'(bad), 32'd0);
        chk("scroll_row23", 32'(mem[1840]), 32'h61);
        chk("scroll_row2", 32'(mem[160]), 32'h78);
        chk("scroll_row24", 32'(count_val(1920, 1999, 8'h20)), 32'd80);
        chk_cursor("scroll", 24, 5);

        // T5: form feed, then reset in the middle of a scroll
        w0 = wr_cnt;
        send(8'h0C);
        wait_idle(2200, "ff_timeout");
        chk("ff_writes", 32'(wr_cnt - w0), 32'd2000);
        chk("ff_blanks", 32'(count_val(0, 1999, 8'h20)), 32'd2000);
        chk_cursor("ff", 0, 0);
        repeat (25) send(8'h0A);
        repeat (100) @(negedge clock);
        chk("mid_scroll_busy", 32'(tif.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(tif.cs_n), 32'd1);
        chk("abort_oe_n", 32'(tif.oe_n), 32'd1);
        chk("abort_we_n", 32'(tif.we_n), 32'd1);
        chk("abort_ready", 32'(tif.in_ready), 32'd0);
        chk_cursor("abort", 0, 0);
        @(negedge clock);
        reset_n = 1'b1;
        w0 = wr_cnt;
        #1;
        chk("restart_addr", 32'(tif.address), 32'd0);
        chk("restart_we_n", 32'(tif.we_n), 32'd0);
        wait_idle(2200, "restart_timeout");
        chk("restart_writes", 32'(wr_cnt - w0), 32'd2000);
        chk("restart_blanks", 32'(count_val(0, 1999, 8'h20)), 32'd2000);
        chk_cursor("restart", 0, 0);

        // T6: unsupported control bytes back-to-back with in_valid held
        send(8'h5A);
        wait_idle(20, "z_timeout");
        chk("z_mem", 32'(mem[0]), 32'h5A);
        b0 = bus_cnt;
        @(negedge clock);
        tif.in_data  = 8'h07;
        tif.in_valid = 1'b1;
        @(posedge clock);
        #1 tif.in_data = 8'h7F;
        @(posedge clock);
        #1 tif.in_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("ign_no_bus", 32'(bus_cnt - b0), 32'd0);
        chk("ign_ready", 32'(tif.in_ready), 32'd1);
        chk("ign_busy", 32'(tif.busy), 32'd0);
        chk_cursor("ign", 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
